// File: rtl/hart_sync_ctrl.sv
// hart_sync_ctrl: barrier controller for a group of harts.
//
// A start request latches the set of participating harts and elects one of
// them as master. The controller then waits until every participating hart
// reports arrival, raises a level release interrupt to each of them, and
// waits for every interrupt to be taken and every arrival flag to drop
// before signalling completion.
//
// Optional feature: define HART_SYNC_CTRL_TIMEOUT_EN to add a gather timeout.
// When it is undefined there is no counter, timeout_cycles_i is ignored and
// timeout_o is tied low.
//
// Ports:
//   clk_i                  clock, rising edge
//   rst_ni                 synchronous active-low reset
//   sync_req_i             start-barrier request, honoured only when idle
//   hart_mask_i            participating harts, sampled with sync_req_i
//   initial_sync_master_i  per-hart master-candidate flags
//   hart_ack_i             per-hart "arrived at barrier" level
//   hart_intc_ack_i        per-hart "release interrupt taken" level
//   timeout_cycles_i       gather timeout in cycles, 0 disables
//   sync_irq_o             per-hart release interrupt, level
//   master_o               one-hot elected master
//   busy_o                 controller not idle
//   done_o                 one-cycle pulse on completion or abort
//   timeout_o              sticky: last barrier aborted on timeout
module hart_sync_ctrl #(
    parameter int unsigned NHARTS    = 3,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sync_req_i,
    input  logic [NHARTS-1:0]    hart_mask_i,
    input  logic [NHARTS-1:0]    initial_sync_master_i,
    input  logic [NHARTS-1:0]    hart_ack_i,
    input  logic [NHARTS-1:0]    hart_intc_ack_i,
    input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
    output logic [NHARTS-1:0]    sync_irq_o,
    output logic [NHARTS-1:0]    master_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        StIdle,
        StGather,
        StRelease,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [NHARTS-1:0] mask_q, mask_d;
    logic [NHARTS-1:0] master_q, master_d;
    logic [NHARTS-1:0] irq_q, irq_d;
    logic              done_q, done_d;

    logic [NHARTS-1:0] acked;
    logic [NHARTS-1:0] cand;
    logic [NHARTS-1:0] pick;
    logic [NHARTS-1:0] elect;

`ifdef HART_SYNC_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] tmo_last;
    logic                 timeout_q, timeout_d;

    assign tmo_last  = timeout_cycles_i - TIMEOUT_W'(1);
    assign timeout_o = timeout_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_cycles_i;
    assign timeout_o      = 1'b0;
`endif

    // Prefer a flagged candidate among participants, else any participant;
    // x & -x isolates the lowest set bit.
    assign cand  = initial_sync_master_i & hart_mask_i;
    assign pick  = (cand != '0) ? cand : hart_mask_i;
    assign elect = pick & (-pick);

    // Arrival flags of non-participating harts are ignored.
    assign acked = hart_ack_i & mask_q;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        master_d = master_q;
        irq_d    = irq_q;
        done_d   = 1'b0;
`ifdef HART_SYNC_CTRL_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (sync_req_i) begin
                    if (hart_mask_i != '0) begin
                        mask_d   = hart_mask_i;
                        master_d = elect;
                        state_d  = StGather;
`ifdef HART_SYNC_CTRL_TIMEOUT_EN
                        cnt_d     = '0;
                        timeout_d = 1'b0;
`endif
                    end else begin
                        // Empty barrier completes trivially.
                        done_d = 1'b1;
                    end
                end
            end
            StGather: begin
`ifdef HART_SYNC_CTRL_TIMEOUT_EN
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
`endif
                // Completion takes priority over a simultaneous timeout.
                if (acked == mask_q) begin
                    state_d = StRelease;
`ifdef HART_SYNC_CTRL_TIMEOUT_EN
                end else if (timeout_cycles_i != '0 && cnt_q == tmo_last) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StIdle;
`endif
                end
            end
            StRelease: begin
                irq_d   = mask_q;
                state_d = StDrain;
            end
            StDrain: begin
                // Bits only ever clear here, so a taken interrupt stays taken.
                irq_d = irq_q & ~hart_intc_ack_i;
                if (irq_q == '0 && acked == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            mask_q   <= '0;
            master_q <= '0;
            irq_q    <= '0;
            done_q   <= 1'b0;
`ifdef HART_SYNC_CTRL_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            master_q <= master_d;
            irq_q    <= irq_d;
            done_q   <= done_d;
`ifdef HART_SYNC_CTRL_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign sync_irq_o = irq_q;
    assign master_o   = master_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;

endmodule

// File: tb/tb_hart_sync_ctrl.sv
// Scoreboard bench for hart_sync_ctrl (NHARTS=3). Stimulus pushes expected
// release-interrupt changes and done pulses, with their cycle stamps, into a
// queue; the monitor pops and compares whenever the DUT shows such an event.
module tb_hart_sync_ctrl;

    localparam int unsigned NH = 3;
    localparam int unsigned TW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [NH-1:0] mask;
    logic [NH-1:0] flags;
    logic [NH-1:0] ack;
    logic [NH-1:0] intc;
    logic [TW-1:0] tmo;
    logic [NH-1:0] irq;
    logic [NH-1:0] master;
    logic          busy;
    logic          done;
    logic          timeout;

    hart_sync_ctrl #(
        .NHARTS   (NH),
        .TIMEOUT_W(TW)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .sync_req_i           (req),
        .hart_mask_i          (mask),
        .initial_sync_master_i(flags),
        .hart_ack_i           (ack),
        .hart_intc_ack_i      (intc),
        .timeout_cycles_i     (tmo),
        .sync_irq_o           (irq),
        .master_o             (master),
        .busy_o               (busy),
        .done_o               (done),
        .timeout_o            (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_done;
        logic [NH-1:0] irq;
        logic [NH-1:0] mst;
        logic          tmo;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [NH-1:0] prev_irq = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_irq(input logic [NH-1:0] v, input int c);
        exp_t e;
        e.is_done = 1'b0; e.irq = v; e.mst = '0; e.tmo = 1'b0; e.cyc = c;
        sb.push_back(e);
    endfunction

    function automatic void push_done(input logic [NH-1:0] m, input logic t, input int c);
        exp_t e;
        e.is_done = 1'b1; e.irq = '0; e.mst = m; e.tmo = t; e.cyc = c;
        sb.push_back(e);
    endfunction

    task automatic check_event(input bit is_done);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got done=%0b irq=%b master=%b at cyc %0d, required none",
                     is_done, irq, master, cyc);
        end else begin
            e = sb.pop_front();
            if (e.is_done != is_done || e.cyc != cyc ||
                (is_done ? (master !== e.mst || timeout !== e.tmo) : (irq !== e.irq))) begin
                n_fail++;
                $display("FAIL event: got done=%0b cyc=%0d irq=%b master=%b timeout=%b, required done=%0b cyc=%0d irq=%b master=%b timeout=%b",
                         is_done, cyc, irq, master, timeout,
                         e.is_done, e.cyc, e.irq, e.mst, e.tmo);
            end
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) check_event(1'b1);
        if (irq !== prev_irq) check_event(1'b0);
        prev_irq = irq;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        rst_n = 1'b0; req = 1'b0; mask = '0; flags = '0; ack = '0; intc = '0; tmo = '0;
        tick(2);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_master", 32'(master), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst_n = 1'b1;
        tick(1);

        // Full barrier, all acks already high: irq 3 cycles after request.
        n = cyc; mask = 3'b111; flags = 3'b000; ack = 3'b111; req = 1'b1;
        push_irq(3'b111, n + 3);
        tick(1); req = 1'b0;
        chk("a_busy", 32'(busy), 1);
        chk("a_master", 32'(master), 32'b001);
        tick(2);
        intc = 3'b111; ack = '0;
        push_irq(3'b000, cyc + 1);
        push_done(3'b001, 1'b0, cyc + 2);
        tick(4); intc = '0;

        // Partial mask, flagged master; foreign ack and early intc ignored.
        n = cyc; mask = 3'b110; flags = 3'b101; ack = 3'b001; req = 1'b1;
        tick(1); req = 1'b0; intc = 3'b111;
        tick(5);
        chk("b_busy", 32'(busy), 1);
        chk("b_irq_quiet", 32'(irq), 0);
        chk("b_master", 32'(master), 32'b100);
        ack = 3'b110; intc = '0;
        push_irq(3'b110, cyc + 2);
        tick(2);
        intc = 3'b110; ack = '0;
        push_irq(3'b000, cyc + 1);
        push_done(3'b100, 1'b0, cyc + 2);
        tick(4); intc = '0;

        // Staggered interrupt acknowledges.
        n = cyc; mask = 3'b111; flags = 3'b010; ack = 3'b111; req = 1'b1;
        push_irq(3'b111, n + 3);
        tick(1); req = 1'b0;
        tick(2);
        t = cyc; intc = 3'b010;
        push_irq(3'b101, t + 1);
        tick(2); intc = 3'b011;
        push_irq(3'b100, t + 3);
        tick(3); intc = 3'b111;
        push_irq(3'b000, t + 6);
        tick(4); ack = '0;
        push_done(3'b010, 1'b0, t + 10);
        tick(4); intc = '0;

        // Empty mask: single done, master unchanged, never busy.
        n = cyc; mask = 3'b000; req = 1'b1;
        push_done(3'b010, 1'b0, n + 1);
        tick(1); req = 1'b0;
        chk("d_busy_empty", 32'(busy), 0);
        chk("d_master_kept", 32'(master), 32'b010);

        // Request during DRAIN is dropped.
        n = cyc; mask = 3'b001; flags = 3'b000; ack = 3'b001; req = 1'b1;
        push_irq(3'b001, n + 3);
        tick(1); req = 1'b0;
        tick(2);
        mask = 3'b111; req = 1'b1; intc = 3'b001; ack = '0;
        push_irq(3'b000, cyc + 1);
        push_done(3'b001, 1'b0, cyc + 2);
        tick(1); req = 1'b0;
        tick(2);
        chk("d_idle_after", 32'(busy), 0);
        tick(3); intc = '0;

        // Reset during DRAIN with irq=101: no done pulse.
        n = cyc; mask = 3'b111; flags = 3'b000; ack = 3'b111; req = 1'b1;
        push_irq(3'b111, n + 3);
        tick(1); req = 1'b0;
        tick(2); intc = 3'b010;
        push_irq(3'b101, cyc + 1);
        tick(2);
        chk("e_irq_pre", 32'(irq), 32'b101);
        rst_n = 1'b0; intc = '0;
        push_irq(3'b000, cyc + 1);
        tick(1);
        chk("e_master", 32'(master), 0);
        chk("e_busy", 32'(busy), 0);
        chk("e_done", 32'(done), 0);
        chk("e_timeout", 32'(timeout), 0);
        rst_n = 1'b1; ack = '0;
        tick(2);

`ifdef HART_SYNC_CTRL_TIMEOUT_EN
        // Timeout after 10 gather cycles, no interrupt.
        n = cyc; mask = 3'b111; flags = 3'b000; ack = 3'b011; tmo = 16'd10; req = 1'b1;
        push_done(3'b001, 1'b1, n + 11);
        tick(1); req = 1'b0;
        tick(10);
        chk("t_timeout", 32'(timeout), 1);
        chk("t_idle", 32'(busy), 0);
        tick(2);
        chk("t_sticky", 32'(timeout), 1);
        n = cyc; mask = 3'b001; ack = 3'b001; req = 1'b1;
        push_irq(3'b001, n + 3);
        tick(1); req = 1'b0;
        chk("t_cleared", 32'(timeout), 0);
        tick(2); intc = 3'b001; ack = '0;
        push_irq(3'b000, cyc + 1);
        push_done(3'b001, 1'b0, cyc + 2);
        tick(4); intc = '0;

        // Completion and timeout in the same cycle: completion wins.
        n = cyc; mask = 3'b001; ack = 3'b001; tmo = 16'd1; req = 1'b1;
        push_irq(3'b001, n + 3);
        tick(1); req = 1'b0;
        tick(2); intc = 3'b001; ack = '0;
        push_irq(3'b000, cyc + 1);
        push_done(3'b001, 1'b0, cyc + 2);
        tick(4); intc = '0; tmo = '0;
`else
        // Without the timeout feature gather waits indefinitely.
        n = cyc; mask = 3'b111; flags = 3'b000; ack = 3'b011; tmo = 16'd10; req = 1'b1;
        tick(1); req = 1'b0;
        tick(20);
        chk("n_still_busy", 32'(busy), 1);
        chk("n_timeout_low", 32'(timeout), 0);
        ack = 3'b111;
        push_irq(3'b111, cyc + 2);
        tick(2); intc = 3'b111; ack = '0;
        push_irq(3'b000, cyc + 1);
        push_done(3'b001, 1'b0, cyc + 2);
        tick(4); intc = '0; tmo = '0;
`endif

        tick(10);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hart_sync_ctrl.md
HART_SYNC_CTRL -- requirements
Module: hart_sync_ctrl

Interface
REQ-001 Parameter NHARTS, default 3: number of harts under barrier control (range 1..8).
REQ-002 Parameter TIMEOUT_W, default 16: width of the gather timeout counter.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low.
REQ-005 sync_req_i  input  1  start-barrier request; sampled only in IDLE.
REQ-006 hart_mask_i  input  NHARTS  participating harts; sampled with sync_req_i.
REQ-007 initial_sync_master_i  input  NHARTS  per-hart master-candidate flags from the private register blocks.
REQ-008 hart_ack_i  input  NHARTS  per-hart level "arrived at barrier", from the private register blocks.
REQ-009 hart_intc_ack_i  input  NHARTS  per-hart level "release interrupt taken".
REQ-010 timeout_cycles_i  input  TIMEOUT_W  gather timeout in cycles; 0 disables the timeout.
REQ-011 sync_irq_o  output  NHARTS  per-hart release interrupt, level.
REQ-012 master_o  output  NHARTS  one-hot elected master for the current barrier.
REQ-013 busy_o  output  1  high whenever the state is not IDLE.
REQ-014 done_o  output  1  one-cycle pulse at barrier completion or abort.
REQ-015 timeout_o  output  1  sticky flag: the last barrier aborted on timeout.

Function
REQ-016 The FSM SHALL have the states IDLE, GATHER, RELEASE and DRAIN, with IDLE entered on reset.
REQ-017 In IDLE with sync_req_i=1 and hart_mask_i nonzero: latch mask_q, latch master_o, clear timeout_o, clear the counter, and go to GATHER on the next cycle.
REQ-018 In IDLE with sync_req_i=1 and hart_mask_i=0: pulse done_o on the next cycle, stay in IDLE, and leave master_o unchanged.
REQ-019 Master election at start: master_o is the one-hot of the lowest set bit of (initial_sync_master_i & hart_mask_i); if that is zero, it is the lowest set bit of hart_mask_i; master_o holds until the next accepted start.
REQ-020 GATHER: when (hart_ack_i & mask_q) == mask_q, go to RELEASE the next cycle; ack bits outside mask_q are ignored.
REQ-021 RELEASE: lasts exactly one cycle, then sets irq_q = mask_q (visible on sync_irq_o the following cycle) and goes to DRAIN.
REQ-022 DRAIN: each irq_q bit clears in the cycle after its hart_intc_ack_i is high; a bit already cleared is never re-set.
REQ-023 DRAIN exit: when irq_q == 0 and (hart_ack_i & mask_q) == 0 in the same cycle, pulse done_o and go to IDLE.
REQ-024 sync_req_i outside IDLE SHALL be ignored: no queueing, no error.
REQ-025 Minimum latency from sync_req_i to sync_irq_o is 3 cycles when all masked acks are already high at GATHER entry.
REQ-026 When acks complete and the timeout expires in the same cycle, completion wins: go to RELEASE and leave timeout_o at 0.
REQ-027 hart_intc_ack_i in GATHER or RELEASE SHALL have no effect.

Reset
REQ-028 On a clock edge with rst_ni=0: state=IDLE, sync_irq_o=0, master_o=0, busy_o=0, done_o=0, timeout_o=0, counter=0, mask_q=0.
REQ-029 Reset asserted mid-barrier SHALL abort it with no done_o pulse, and all outputs reach reset values one edge later.

Configuration
REQ-030 Macro HART_SYNC_CTRL_TIMEOUT_EN defined: in GATHER the counter increments by 1 per cycle, saturating at its maximum value.
REQ-031 With the macro defined and timeout_cycles_i != 0: when counter == timeout_cycles_i - 1 without completion, set timeout_o, pulse done_o, go to IDLE, and assert no sync_irq_o.
REQ-032 Macro undefined: no counter is instantiated, timeout_cycles_i is ignored, timeout_o is tied to 0, and GATHER waits indefinitely.

Verification
REQ-033 NHARTS=3, mask=3'b111, master flags 3'b000, all acks already high -> master_o=3'b001, sync_irq_o=3'b111 3 cycles after sync_req_i; intc acks plus acks low -> done_o pulses once.
REQ-034 mask=3'b110, master flags 3'b101 -> master_o=3'b100; hart_ack_i=3'b001 never completes the barrier; hart_ack_i=3'b110 completes it.
REQ-035 TIMEOUT_EN defined, timeout_cycles_i=10, hart_ack_i=3'b011 with mask 3'b111 -> done_o and timeout_o after 10 GATHER cycles, sync_irq_o stays 0; the next start clears timeout_o.
REQ-036 Staggered intc acks (hart1 at t, hart0 at t+2, hart2 at t+5) -> each irq bit drops one cycle after its ack; done_o only after the last ack and all hart_ack_i low.
REQ-037 sync_req_i=1 with mask=0 -> single done_o pulse, busy_o stays 0; sync_req_i pulsed during DRAIN -> ignored, exactly one done_o.
REQ-038 rst_ni=0 asserted during DRAIN with sync_irq_o=3'b101 -> all outputs 0 after one edge, no done_o pulse.
